fetch_unit: RTL and testbench

Instruction-fetch stage sitting directly upstream of the IF/ID pipeline register. It owns the PC register and issues single-outstanding requests to a variable-latency instruction memory. It buffers one fetched instruction with its PC, to be consumed by IF/ID via the stall signal, and handles branch redirects by flushing the buffer and discarding any in-flight response.

---
 rtl/fetch_unit.sv | 110 +++++++++++
 tb/tb_fetch_unit.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage feeding the IF/ID register.
// Owns the PC, keeps at most one request in flight to a variable-latency
// instruction memory, and buffers one fetched instruction with its PC.
// A redirect flushes the buffer and discards any response still in flight.
module fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          PC_INC   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_write,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [63:0] if_pc,
    output logic [31:0] if_instr,
    output logic        if_valid
);

    // FETCH: free to issue; WAIT: response pending and wanted;
    // DROP: response pending but stale after a redirect.
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DROP  = 2'd2
    } state_t;

    state_t      state_reg;
    logic [63:0] pc_reg;
    logic        if_valid_reg;
    logic [63:0] if_pc_reg;
    logic [31:0] if_instr_reg;

    logic        consume;
    logic        issue;
    logic [63:0] redirect_target;
    logic        redirect_lsb_unused;

    // IF/ID takes the buffered instruction this cycle.
    assign consume = if_valid_reg && pc_write;

    // Only issue when the buffer is empty or being drained this cycle, so a
    // returning response always finds room.
    assign imem_req = !reset && (state_reg == FETCH) && !redirect
                      && (!if_valid_reg || pc_write);
    assign issue    = imem_req && imem_ready;

    // Targets are word aligned; the low two bits are ignored.
    assign redirect_target     = {redirect_pc[63:2], 2'b00};
    assign redirect_lsb_unused = ^redirect_pc[1:0];

    assign imem_addr = pc_reg;
    assign if_pc     = if_pc_reg;
    assign if_instr  = if_instr_reg;
    assign if_valid  = if_valid_reg;

    // PC, fetch state and output buffer; redirect outranks every other event.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_reg       <= RESET_PC;
            state_reg    <= FETCH;
            if_valid_reg <= 1'b0;
            if_pc_reg    <= 64'h0;
            if_instr_reg <= 32'h0;
        end else if (redirect) begin
            pc_reg       <= redirect_target;
            if_valid_reg <= 1'b0;
            if_instr_reg <= 32'h0;
            case (state_reg)
                FETCH:   state_reg <= FETCH;
                WAIT,
                DROP:    state_reg <= imem_rvalid ? FETCH : DROP;
                default: state_reg <= FETCH;
            endcase
        end else begin
            // Drained buffer empties unless a response refills it below.
            if (consume) begin
                if_valid_reg <= 1'b0;
                if_instr_reg <= 32'h0;
            end
            case (state_reg)
                FETCH: begin
                    if (issue) begin
                        state_reg <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        if_valid_reg <= 1'b1;
                        if_pc_reg    <= pc_reg;
                        if_instr_reg <= imem_rdata;
                        pc_reg       <= pc_reg + 64'(PC_INC);
                        state_reg    <= FETCH;
                    end
                end
                DROP: begin
                    if (imem_rvalid) begin
                        state_reg <= FETCH;
                    end
                end
                default: state_reg <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a latency-programmable memory model answers
// requests, the stimulus pushes the instructions it expects IF/ID to capture,
// and a negedge monitor pops and compares them as they are consumed.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        pc_write;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [63:0] if_pc;
    logic [31:0] if_instr;
    logic        if_valid;

    // Second instance for the wrap-around reset PC.
    logic        req_w;
    logic [63:0] addr_w;
    logic        rvalid_w;
    logic [31:0] rdata_w;
    logic [63:0] if_pc_w;
    logic [31:0] if_instr_w;
    logic        if_valid_w;

    int n_cmp = 0;
    int n_bad = 0;
    int lat;
    logic [95:0] exp_q[$];

    fetch_unit #(.RESET_PC(64'h0), .PC_INC(4)) dut (
        .clk(clk), .reset(reset), .pc_write(pc_write), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .if_pc(if_pc), .if_instr(if_instr), .if_valid(if_valid)
    );

    fetch_unit #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC), .PC_INC(4)) dut_w (
        .clk(clk), .reset(reset), .pc_write(1'b1), .redirect(1'b0),
        .redirect_pc(64'h0), .imem_req(req_w), .imem_addr(addr_w),
        .imem_ready(1'b1), .imem_rvalid(rvalid_w), .imem_rdata(rdata_w),
        .if_pc(if_pc_w), .if_instr(if_instr_w), .if_valid(if_valid_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memfn(input logic [63:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory for the main instance: samples the pre-edge request, answers
    // 'lat' cycles after the issue, drops everything on reset.
    logic        mem_busy = 1'b0;
    int          mem_cnt = 0;
    logic [63:0] mem_addr = 64'h0;
    initial begin
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
    end
    always begin
        logic        iss;
        logic [63:0] a;
        logic        had_rv;
        @(posedge clk);
        iss    = imem_req && imem_ready;
        a      = imem_addr;
        had_rv = imem_rvalid;
        #1;
        if (reset) begin
            mem_busy    = 1'b0;
            imem_rvalid = 1'b0;
        end else begin
            if (had_rv) begin
                imem_rvalid = 1'b0;
                mem_busy    = 1'b0;
            end
            if (iss) begin
                mem_busy = 1'b1;
                mem_cnt  = lat;
                mem_addr = a;
            end
            if (mem_busy && !imem_rvalid) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = memfn(mem_addr);
                end
            end
        end
    end

    // One-cycle memory for the wrap instance.
    initial begin
        rvalid_w = 1'b0;
        rdata_w  = 32'h0;
    end
    always begin
        logic        iss;
        logic [63:0] a;
        @(posedge clk);
        iss = req_w;
        a   = addr_w;
        #1;
        rvalid_w = iss && !reset;
        rdata_w  = memfn(a);
    end

    // Scoreboard monitor: compare each instruction as IF/ID captures it.
    always @(negedge clk) begin
        if (!reset) begin
            if (if_valid && pc_write) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_instr: got pc %h instr %h expected none", if_pc, if_instr);
                end else begin
                    logic [95:0] e;
                    e = exp_q.pop_front();
                    $display("capture pc=%h instr=%h", if_pc, if_instr);
                    check("if_pc", if_pc, e[95:32]);
                    check("if_instr", 64'(if_instr), 64'(e[31:0]));
                end
            end
            if (!if_valid) check("instr_zero_when_invalid", 64'(if_instr), 64'h0);
        end
    end

    task automatic next();
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset       = 1'b1;
        pc_write    = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 64'h0;
        imem_ready  = 1'b1;
        lat         = 1;
        exp_q.push_back({64'h0,   32'hC0DE_0000});
        exp_q.push_back({64'h4,   32'hC0DE_0004});
        exp_q.push_back({64'h8,   32'hC0DE_0008});
        exp_q.push_back({64'hC,   32'hC0DE_000C});
        exp_q.push_back({64'h100, 32'hC0DE_0100});
        exp_q.push_back({64'h504, 32'hC0DE_0504});
        exp_q.push_back({64'h0,   32'hC0DE_0000});

        repeat (3) @(posedge clk);
        #1;
        check("reset_req", 64'(imem_req), 64'h0);
        check("reset_valid", 64'(if_valid), 64'h0);
        check("reset_pc_out", if_pc, 64'h0);
        #1;
        reset = 1'b0;
        // C0: sequential fetch from RESET_PC
        #1;
        check("c0_req", 64'(imem_req), 64'h1);
        check("c0_addr", imem_addr, 64'h0);
        check("wrap_c0_addr", addr_w, 64'hFFFF_FFFF_FFFF_FFFC);
        next(); next();                        // C2
        #1;
        check("c2_addr", imem_addr, 64'h4);
        check("c2_req", 64'(imem_req), 64'h1);
        check("wrap_valid", 64'(if_valid_w), 64'h1);
        check("wrap_if_pc", if_pc_w, 64'hFFFF_FFFF_FFFF_FFFC);
        check("wrap_if_instr", 64'(if_instr_w), 64'hC0DE_FFFC);
        check("wrap_next_addr", addr_w, 64'h0);
        next(); next();                        // C4
        #1;
        check("c4_addr", imem_addr, 64'h8);
        next(); next();                        // C6: stall holding pc 8
        pc_write = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k != 0) next();
            #1;
            check("stall_req", 64'(imem_req), 64'h0);
            check("stall_if_pc", if_pc, 64'h8);
            check("stall_if_instr", 64'(if_instr), 64'hC0DE_0008);
            check("stall_valid", 64'(if_valid), 64'h1);
        end
        next();                                // C11
        pc_write = 1'b1;
        #1;
        check("post_stall_addr", imem_addr, 64'hC);
        check("post_stall_req", 64'(imem_req), 64'h1);
        next(); next();                        // C13: issue 16 with latency 3
        lat = 3;
        next();                                // C14: redirect in WAIT
        redirect    = 1'b1;
        redirect_pc = 64'h103;
        next();                                // C15: DROP
        redirect = 1'b0;
        #1;
        check("drop_req", 64'(imem_req), 64'h0);
        check("drop_addr", imem_addr, 64'h100);
        next();                                // C16: stale response arrives
        #1;
        check("drop_no_load", 64'(if_valid), 64'h0);
        next();                                // C17
        #1;
        check("redir_req", 64'(imem_req), 64'h1);
        check("redir_addr", imem_addr, 64'h100);
        repeat (4) next();                     // C21
        #1;
        check("c21_addr", imem_addr, 64'h104);
        repeat (3) next();                     // C24: redirect with rvalid
        redirect    = 1'b1;
        redirect_pc = 64'h200;
        next();                                // C25
        redirect = 1'b0;
        #1;
        check("coinc_valid", 64'(if_valid), 64'h0);
        check("coinc_req", 64'(imem_req), 64'h1);
        check("coinc_addr", imem_addr, 64'h200);
        next();                                // C26: WAIT -> DROP
        redirect    = 1'b1;
        redirect_pc = 64'h300;
        next();                                // C27: second redirect in DROP
        redirect_pc = 64'h400;
        #1;
        check("drop1_addr", imem_addr, 64'h300);
        check("drop1_req", 64'(imem_req), 64'h0);
        next();                                // C28: redirect with rvalid in DROP
        redirect_pc = 64'h504;
        lat         = 1;
        #1;
        check("drop2_addr", imem_addr, 64'h400);
        next();                                // C29
        redirect = 1'b0;
        #1;
        check("last_wins_req", 64'(imem_req), 64'h1);
        check("last_wins_addr", imem_addr, 64'h504);
        next(); next();                        // C31
        lat = 3;
        #1;
        check("c31_addr", imem_addr, 64'h508);
        next();                                // C32: WAIT, async reset between edges
        #1;
        reset = 1'b1;
        #1;
        check("async_valid", 64'(if_valid), 64'h0);
        check("async_if_pc", if_pc, 64'h0);
        check("async_if_instr", 64'(if_instr), 64'h0);
        check("async_req", 64'(imem_req), 64'h0);
        check("async_addr", imem_addr, 64'h0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        lat   = 1;
        #1;
        check("restart_req", 64'(imem_req), 64'h1);
        check("restart_addr", imem_addr, 64'h0);
        repeat (4) next();
        check("queue_drained", 64'(exp_q.size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
